// File: rtl/capture_reader.sv
// capture_reader: Wishbone read master draining the sniffer sample ring.
// Define CAPTURE_READER_LEVEL_EN to add the registered level_o output.
module capture_reader #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          BUFFER_WORDS = 16384,
    parameter int          FIFO_DEPTH   = 4,
    localparam int         PTR_W        = $clog2(BUFFER_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             ptr_load_i,
    input  logic [PTR_W-1:0] wr_ptr_i,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic             busy_o,
    output logic [31:0]      mem_addr_o,
    output logic [3:0]       mem_sel_o,
    output logic             mem_we_o,
    output logic             mem_stb_o,
    output logic             mem_cyc_o,
    input  logic             mem_stall_i,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_data_i,
    output logic [31:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i
`ifdef CAPTURE_READER_LEVEL_EN
    , output logic [PTR_W:0] level_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [IDX_W-1:0] fifo_wr_q, fifo_wr_d;
    logic [IDX_W-1:0] fifo_rd_q, fifo_rd_d;
    logic [31:0]      fifo_mem_q [FIFO_DEPTH];
    logic [31:0]      fifo_mem_d [FIFO_DEPTH];
    logic             stb_q, stb_d;
    logic [31:0]      addr_q, addr_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             ack;
    logic             push;
    logic             pop;
    logic             load;
    logic [PTR_W-1:0] pending_d;
    logic [CNT_W:0]   used_d;
    logic             issue_d;

    always_comb begin
        accept = stb_q & ~mem_stall_i;
        ack    = mem_ack_i & (outst_q != '0);
        load   = (state_q == IDLE) & ptr_load_i;
        push   = ack & ~load;
        pop    = (fifo_cnt_q != '0) & ready_i & ~load;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (enable_i) begin
                    state_d = RUN;
                end else if (outst_q == '0 && !stb_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_ptr_d = fetch_ptr_q + PTR_W'(accept);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        outst_d     = outst_q + CNT_W'(accept) - CNT_W'(ack);
        fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        fifo_wr_d   = fifo_wr_q + IDX_W'(push);
        fifo_rd_d   = fifo_rd_q + IDX_W'(pop);
        fifo_mem_d  = fifo_mem_q;
        if (push) begin
            fifo_mem_d[fifo_wr_q] = mem_data_i;
        end
        if (load) begin
            fetch_ptr_d = wr_ptr_i;
            rd_ptr_d    = wr_ptr_i;
            fifo_cnt_d  = '0;
            fifo_wr_d   = '0;
            fifo_rd_d   = '0;
        end
    end

    // Credits are judged on next-cycle counts so a back-to-back strobe
    // can never push the FIFO past its depth.
    always_comb begin
        pending_d = wr_ptr_i - fetch_ptr_d;
        used_d    = {1'b0, outst_d} + {1'b0, fifo_cnt_d};
        issue_d   = (state_q == RUN) & enable_i
                  & (pending_d != '0) & (used_d < DEPTH_L);
        stb_d     = (stb_q & mem_stall_i) | issue_d;
        addr_d    = BASE_ADDR + 32'({fetch_ptr_d, 2'b00});
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            outst_q     <= '0;
            fifo_cnt_q  <= '0;
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            stb_q       <= 1'b0;
            addr_q      <= BASE_ADDR;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            outst_q     <= outst_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_mem_q  <= fifo_mem_d;
            stb_q       <= stb_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
        end
    end

`ifdef CAPTURE_READER_LEVEL_EN
    logic [PTR_W:0] level_q, level_d;

    always_comb begin
        level_d = {1'b0, wr_ptr_i - rd_ptr_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
`endif

    assign rd_ptr_o   = rd_ptr_q;
    assign busy_o     = busy_q;
    assign mem_addr_o = addr_q;
    assign mem_sel_o  = 4'hF;
    assign mem_we_o   = 1'b0;
    assign mem_stb_o  = stb_q;
    assign mem_cyc_o  = stb_q | (outst_q != '0);
    assign data_o     = fifo_mem_q[fifo_rd_q];
    assign valid_o    = (fifo_cnt_q != '0);

endmodule
